writeback_stage_p: RTL and testbench
====================================

Name: writeback_stage_p

Overview:
- Parametrised next-generation writeback stage of the 5-stage RISC-V pipeline. Sits between the memory stage and the register file.
- Selects the result from one of four sources and formats load data (byte/half/word, signed/unsigned).
- Registers the write-back triple (rd, data, write enable) with valid/stall/flush control, drives a same-cycle forwarding path, flags misaligned loads and counts retired instructions.

Parameters:
- XLEN, 32, datapath width in bits (32 or 64).
- REG_AW, 5, register-address width.
- CNT_W, 64, width of the retired-instruction counter.

Ports:
- clk  input  1  pipeline clock, rising edge
- rst  input  1  asynchronous, active-high reset
- valid_i  input  1  instruction present in W input
- stall_i  input  1  hold the output register
- flush_i  input  1  kill the instruction being captured
- reg_write_i  input  1  instruction writes rd
- result_src_i  input  2  0=ALU, 1=load data, 2=PC+4, 3=immediate
- funct3_i  input  3  load size/sign (000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; 011/110 ld/lwu only when XLEN=64)
- rd_i  input  REG_AW  destination register
- alu_result_i  input  XLEN  ALU result; low bits are the load byte offset
- read_data_i  input  XLEN  raw aligned memory word
- pc_plus4_i  input  XLEN  link value
- imm_i  input  XLEN  immediate (lui)
- result_o  output  XLEN  registered write data to the register file
- rd_o  output  REG_AW  registered destination
- reg_write_o  output  1  registered write enable
- valid_o  output  1  registered valid
- fwd_result_o  output  XLEN  combinational formatted result of the current input (bypass)
- fwd_en_o  output  1  combinational: valid_i & reg_write_i & rd_i!=0 & ~misalign
- misalign_o  output  1  registered one-cycle pulse: misaligned load retired-as-killed
- retired_o  output  CNT_W  retired-instruction count

Behaviour:
- Reset (rst=1, asynchronous): result_o=0, rd_o=0, reg_write_o=0, valid_o=0, misalign_o=0, retired_o=0. Reset takes effect immediately, including mid-stall.
- Mux: the source is chosen by result_src_i. The load path shifts read_data_i right by 8*offset. The offset is alu_result_i[1:0] for XLEN=32 and [2:0] for XLEN=64.
  - Byte and half loads are sign- or zero-extended to XLEN per funct3_i.
  - An unsupported funct3 yields the unshifted word.
- Misalignment, checked only when result_src_i=1:
  - half: offset[0]!=0
  - word: offset[1:0]!=0
  - double: offset!=0
  - Effect: the write enable is forced to 0, and misalign_o=1 in the next cycle.
- x0 protection: when rd_i=0, the registered reg_write_o is 0.
- Latency: one cycle from input to registered outputs. fwd_* outputs have zero latency.
- Priority on the clock edge: flush_i > stall_i > normal capture.
  - flush: valid_o, reg_write_o and misalign_o are set to 0; result_o and rd_o are don't-care but cleared to 0.
  - stall (no flush): all registered outputs hold, except misalign_o, which is cleared after one cycle so it stays a pulse.
  - normal: valid_o=valid_i. reg_write_o=valid_i & reg_write_i & rd_i!=0 & ~misalign. misalign_o=valid_i & misalign.
- retired_o increments by 1 on each capture edge with valid_i=1, no stall, no flush and no misalignment.
  - It wraps modulo 2^CNT_W.
  - It does not increment during a stall, even when valid_o=1.
- valid_i=0 captures a bubble: reg_write_o=0.

Decomposition:
- Shared package: result-source encodings (RES_ALU, RES_MEM, RES_PC4, RES_IMM) and load funct3 encodings (F3_LB ... F3_LWU). The decode stage reuses the same package.
- One sub-module: load_formatter, combinational (read_data, offset, funct3 -> formatted data, misalign).
- The register and counter logic stay in the top module.

Test Plan:
- Reset: assert rst mid-stream with reg_write_o=1 -> all outputs 0 asynchronously, before the next clock edge; retired_o=0.
- lb, alu_result_i=0x1003, read_data_i=0x80FF_1234 -> result_o=0xFFFF_FF80 one cycle later. lbu with the same inputs -> 0x0000_0080. retired_o increments by 1.
- lh at offset 1 -> reg_write_o=0, misalign_o=1 for exactly one cycle, retired_o unchanged, fwd_en_o=0 in the input cycle.
- rd_i=0 with reg_write_i=1, result_src_i=0 -> reg_write_o=0; valid_o=1; retired_o increments.
- stall_i=1 for 3 cycles with changing inputs -> outputs frozen at the prior values, retired_o constant. stall_i and flush_i together -> valid_o=0, reg_write_o=0.
- Counter wrap with CNT_W=4: 17 retirements -> retired_o=1. jal with result_src_i=2, pc_plus4_i=0x104 -> result_o=0x104.

Source files
------------

// File: rtl/writeback_stage_p_pkg.sv
// Shared encodings for the writeback result mux and load sizes.
// The decode stage imports this package as well.
package writeback_stage_p_pkg;

   localparam logic [1:0] RES_ALU = 2'd0;
   localparam logic [1:0] RES_MEM = 2'd1;
   localparam logic [1:0] RES_PC4 = 2'd2;
   localparam logic [1:0] RES_IMM = 2'd3;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LD  = 3'b011;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_LWU = 3'b110;

endpackage

// File: rtl/writeback_stage_p_load_formatter.sv
// Combinational load data formatter: aligns the addressed bytes, extends them
// to XLEN and flags accesses that are not naturally aligned.
module writeback_stage_p_load_formatter
   import writeback_stage_p_pkg::*;
#(
   parameter int unsigned XLEN = 32,
   parameter int unsigned OffW = 2
) (
   input  logic [XLEN-1:0] readData,
   input  logic [OffW-1:0] offset,
   input  logic [2:0]      funct3,
   output logic [XLEN-1:0] data,
   output logic            misalign
);

   logic [XLEN-1:0] shifted;
   logic [XLEN-1:0] byteS, byteZ, halfS, halfZ, wordS, wordZ;

   assign shifted = readData >> {offset, 3'b000};

   // Extensions are built by overlaying the low bits so no zero-width replication
   // appears when XLEN is 32.
   always_comb begin
      byteS = {XLEN{shifted[7]}};
      byteS[7:0] = shifted[7:0];
      byteZ = '0;
      byteZ[7:0] = shifted[7:0];
      halfS = {XLEN{shifted[15]}};
      halfS[15:0] = shifted[15:0];
      halfZ = '0;
      halfZ[15:0] = shifted[15:0];
      wordS = {XLEN{shifted[31]}};
      wordS[31:0] = shifted[31:0];
      wordZ = '0;
      wordZ[31:0] = shifted[31:0];
   end

   always_comb begin
      data     = readData;
      misalign = 1'b0;
      case (funct3)
         F3_LB:  data = byteS;
         F3_LBU: data = byteZ;
         F3_LH: begin
            data     = halfS;
            misalign = offset[0];
         end
         F3_LHU: begin
            data     = halfZ;
            misalign = offset[0];
         end
         F3_LW: begin
            data     = wordS;
            misalign = (offset[1:0] != 2'b00);
         end
         F3_LD: begin
            if (XLEN == 64) begin
               data     = shifted;
               misalign = (offset != '0);
            end
         end
         F3_LWU: begin
            if (XLEN == 64) begin
               data     = wordZ;
               misalign = (offset[1:0] != 2'b00);
            end
         end
         default: data = readData;
      endcase
   end

endmodule

// File: rtl/writeback_stage_p.sv
// Writeback stage: result select, load formatting, registered write-back triple,
// zero-latency forwarding, misaligned-load pulse and retired-instruction counter.
module writeback_stage_p
   import writeback_stage_p_pkg::*;
#(
   parameter int unsigned XLEN   = 32,
   parameter int unsigned REG_AW = 5,
   parameter int unsigned CNT_W  = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_i,
   input  logic              stall_i,
   input  logic              flush_i,
   input  logic              reg_write_i,
   input  logic [1:0]        result_src_i,
   input  logic [2:0]        funct3_i,
   input  logic [REG_AW-1:0] rd_i,
   input  logic [XLEN-1:0]   alu_result_i,
   input  logic [XLEN-1:0]   read_data_i,
   input  logic [XLEN-1:0]   pc_plus4_i,
   input  logic [XLEN-1:0]   imm_i,
   output logic [XLEN-1:0]   result_o,
   output logic [REG_AW-1:0] rd_o,
   output logic              reg_write_o,
   output logic              valid_o,
   output logic [XLEN-1:0]   fwd_result_o,
   output logic              fwd_en_o,
   output logic              misalign_o,
   output logic [CNT_W-1:0]  retired_o
);

   localparam int unsigned OffW = (XLEN == 64) ? 3 : 2;

   logic [XLEN-1:0]   loadData;
   logic              loadMisalign;
   logic              misalign;
   logic              writeEn;
   logic [XLEN-1:0]   resultD;

   logic [XLEN-1:0]   resultQ;
   logic [REG_AW-1:0] rdQ;
   logic              regWriteQ;
   logic              validQ;
   logic              misalignQ;
   logic [CNT_W-1:0]  retiredQ;

   writeback_stage_p_load_formatter #(
      .XLEN (XLEN),
      .OffW (OffW)
   ) uFormatter (
      .readData (read_data_i),
      .offset   (alu_result_i[OffW-1:0]),
      .funct3   (funct3_i),
      .data     (loadData),
      .misalign (loadMisalign)
   );

   always_comb begin
      resultD = alu_result_i;
      unique case (result_src_i)
         RES_ALU: resultD = alu_result_i;
         RES_MEM: resultD = loadData;
         RES_PC4: resultD = pc_plus4_i;
         RES_IMM: resultD = imm_i;
         default: resultD = alu_result_i;
      endcase
   end

   // Alignment only matters when the load path is actually selected.
   assign misalign = (result_src_i == RES_MEM) && loadMisalign;
   assign writeEn  = valid_i && reg_write_i && (rd_i != '0) && !misalign;

   assign fwd_result_o = resultD;
   assign fwd_en_o     = writeEn;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         resultQ   <= '0;
         rdQ       <= '0;
         regWriteQ <= 1'b0;
         validQ    <= 1'b0;
         misalignQ <= 1'b0;
         retiredQ  <= '0;
      end else if (flush_i) begin
         resultQ   <= '0;
         rdQ       <= '0;
         regWriteQ <= 1'b0;
         validQ    <= 1'b0;
         misalignQ <= 1'b0;
      end else if (stall_i) begin
         // Hold the triple but let the misalign pulse expire.
         misalignQ <= 1'b0;
      end else begin
         resultQ   <= resultD;
         rdQ       <= rd_i;
         regWriteQ <= writeEn;
         validQ    <= valid_i;
         misalignQ <= valid_i && misalign;
         if (valid_i && !misalign) begin
            retiredQ <= retiredQ + 1'b1;
         end
      end
   end

   assign result_o    = resultQ;
   assign rd_o        = rdQ;
   assign reg_write_o = regWriteQ;
   assign valid_o     = validQ;
   assign misalign_o  = misalignQ;
   assign retired_o   = retiredQ;

endmodule

// File: tb/tb_writeback_stage_p.sv
// Directed bench for writeback_stage_p (XLEN=32, CNT_W=4 to exercise counter wrap).
module tb_writeback_stage_p;

   localparam int unsigned XLEN   = 32;
   localparam int unsigned REG_AW = 5;
   localparam int unsigned CNT_W  = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              valid_i, stall_i, flush_i, reg_write_i;
   logic [1:0]        result_src_i;
   logic [2:0]        funct3_i;
   logic [REG_AW-1:0] rd_i;
   logic [XLEN-1:0]   alu_result_i, read_data_i, pc_plus4_i, imm_i;
   logic [XLEN-1:0]   result_o, fwd_result_o;
   logic [REG_AW-1:0] rd_o;
   logic              reg_write_o, valid_o, fwd_en_o, misalign_o;
   logic [CNT_W-1:0]  retired_o;

   int checks = 0;
   int errors = 0;

   writeback_stage_p #(
      .XLEN   (XLEN),
      .REG_AW (REG_AW),
      .CNT_W  (CNT_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .valid_i      (valid_i),
      .stall_i      (stall_i),
      .flush_i      (flush_i),
      .reg_write_i  (reg_write_i),
      .result_src_i (result_src_i),
      .funct3_i     (funct3_i),
      .rd_i         (rd_i),
      .alu_result_i (alu_result_i),
      .read_data_i  (read_data_i),
      .pc_plus4_i   (pc_plus4_i),
      .imm_i        (imm_i),
      .result_o     (result_o),
      .rd_o         (rd_o),
      .reg_write_o  (reg_write_o),
      .valid_o      (valid_o),
      .fwd_result_o (fwd_result_o),
      .fwd_en_o     (fwd_en_o),
      .misalign_o   (misalign_o),
      .retired_o    (retired_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic rw, input logic [1:0] src,
                        input logic [2:0] f3, input logic [REG_AW-1:0] rd,
                        input logic [XLEN-1:0] alu, input logic [XLEN-1:0] rdata);
      valid_i      = v;
      reg_write_i  = rw;
      result_src_i = src;
      funct3_i     = f3;
      rd_i         = rd;
      alu_result_i = alu;
      read_data_i  = rdata;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      stall_i = 1'b0;
      flush_i = 1'b0;
      pc_plus4_i = '0;
      imm_i = '0;
      drive(1'b0, 1'b0, 2'd0, 3'd0, 5'd0, 32'h0, 32'h0);
      tick();
      chk("rst_result", 64'(result_o), 64'h0);
      chk("rst_valid", 64'(valid_o), 64'h0);
      chk("rst_retired", 64'(retired_o), 64'h0);
      rst = 1'b0;

      // lb at offset 3 of 0x80FF1234 -> 0x80 sign-extended
      drive(1'b1, 1'b1, 2'd1, 3'b000, 5'd5, 32'h1003, 32'h80FF_1234);
      #1;
      chk("lb_fwd", 64'(fwd_result_o), 64'hFFFF_FF80);
      chk("lb_fwd_en", 64'(fwd_en_o), 64'h1);
      tick();
      chk("lb_result", 64'(result_o), 64'hFFFF_FF80);
      chk("lb_rd", 64'(rd_o), 64'd5);
      chk("lb_we", 64'(reg_write_o), 64'h1);
      chk("lb_retired", 64'(retired_o), 64'd1);

      drive(1'b1, 1'b1, 2'd1, 3'b100, 5'd5, 32'h1003, 32'h80FF_1234);
      tick();
      chk("lbu_result", 64'(result_o), 64'h0000_0080);
      chk("lbu_retired", 64'(retired_o), 64'd2);

      // lh at offset 1 is misaligned
      drive(1'b1, 1'b1, 2'd1, 3'b001, 5'd6, 32'h1001, 32'h80FF_1234);
      #1;
      chk("lh_mis_fwd_en", 64'(fwd_en_o), 64'h0);
      tick();
      chk("lh_mis_we", 64'(reg_write_o), 64'h0);
      chk("lh_mis_pulse", 64'(misalign_o), 64'h1);
      chk("lh_mis_valid", 64'(valid_o), 64'h1);
      chk("lh_mis_retired", 64'(retired_o), 64'd2);

      // lh at offset 2 -> upper half 0x80FF sign-extended
      drive(1'b1, 1'b1, 2'd1, 3'b001, 5'd6, 32'h1002, 32'h80FF_1234);
      tick();
      chk("lh_pulse_end", 64'(misalign_o), 64'h0);
      chk("lh_result", 64'(result_o), 64'hFFFF_80FF);
      chk("lh_retired", 64'(retired_o), 64'd3);

      drive(1'b1, 1'b1, 2'd1, 3'b010, 5'd7, 32'h2000, 32'hDEAD_BEEF);
      tick();
      chk("lw_result", 64'(result_o), 64'hDEAD_BEEF);
      chk("lw_retired", 64'(retired_o), 64'd4);

      // write to x0 is suppressed but still retires
      drive(1'b1, 1'b1, 2'd0, 3'b000, 5'd0, 32'h55, 32'h0);
      #1;
      chk("x0_fwd_en", 64'(fwd_en_o), 64'h0);
      tick();
      chk("x0_we", 64'(reg_write_o), 64'h0);
      chk("x0_valid", 64'(valid_o), 64'h1);
      chk("x0_retired", 64'(retired_o), 64'd5);

      drive(1'b1, 1'b1, 2'd0, 3'b000, 5'd3, 32'h1234, 32'h0);
      tick();
      chk("alu_result", 64'(result_o), 64'h1234);
      chk("alu_we", 64'(reg_write_o), 64'h1);
      chk("alu_retired", 64'(retired_o), 64'd6);

      stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 2'd0, 3'b000, 5'(9 + i), 32'hAAAA + 32'(i), 32'h0);
         tick();
         chk("stall_result", 64'(result_o), 64'h1234);
         chk("stall_rd", 64'(rd_o), 64'd3);
         chk("stall_we", 64'(reg_write_o), 64'h1);
         chk("stall_retired", 64'(retired_o), 64'd6);
      end

      flush_i = 1'b1;
      tick();
      chk("flush_valid", 64'(valid_o), 64'h0);
      chk("flush_we", 64'(reg_write_o), 64'h0);
      chk("flush_retired", 64'(retired_o), 64'd6);
      flush_i = 1'b0;
      stall_i = 1'b0;

      drive(1'b0, 1'b1, 2'd0, 3'b000, 5'd4, 32'h77, 32'h0);
      tick();
      chk("bubble_valid", 64'(valid_o), 64'h0);
      chk("bubble_we", 64'(reg_write_o), 64'h0);
      chk("bubble_retired", 64'(retired_o), 64'd6);

      pc_plus4_i = 32'h104;
      drive(1'b1, 1'b1, 2'd2, 3'b000, 5'd1, 32'h100, 32'h0);
      tick();
      chk("jal_result", 64'(result_o), 64'h104);
      chk("jal_retired", 64'(retired_o), 64'd7);

      imm_i = 32'h1234_5000;
      drive(1'b1, 1'b1, 2'd3, 3'b000, 5'd2, 32'h0, 32'h0);
      tick();
      chk("lui_result", 64'(result_o), 64'h1234_5000);
      chk("lui_retired", 64'(retired_o), 64'd8);

      drive(1'b1, 1'b1, 2'd0, 3'b000, 5'd8, 32'h9, 32'h0);
      for (int i = 0; i < 8; i++) tick();
      chk("wrap_zero", 64'(retired_o), 64'd0);
      tick();
      chk("wrap_one", 64'(retired_o), 64'd1);

      // asynchronous reset between edges while a write is pending
      chk("pre_rst_we", 64'(reg_write_o), 64'h1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst_we", 64'(reg_write_o), 64'h0);
      chk("arst_valid", 64'(valid_o), 64'h0);
      chk("arst_result", 64'(result_o), 64'h0);
      chk("arst_rd", 64'(rd_o), 64'h0);
      chk("arst_retired", 64'(retired_o), 64'd0);
      rst = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
